// File: rtl/rename_map_table_mw.sv
// Multi-lane rename map table with intra-group bypass and internal branch checkpoints.
// Optional RENAME_CKPT_STATS_EN adds the ckpt_count_o / ckpt_drop_cnt_o statistics outputs.
module rename_map_table_mw #(
  parameter int NUM_ARCH_REGS = 32,
  parameter int PHYS_REG_BITS = 7,
  parameter int WIDTH         = 2,
  parameter int NUM_CKPT      = 4,
  parameter int CKPT_BITS     = $clog2(NUM_CKPT),
  parameter int LANE_BITS     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [WIDTH*5-1:0]               rs1_arch_i,
  input  logic [WIDTH*5-1:0]               rs2_arch_i,
  input  logic [WIDTH*5-1:0]               rd_arch_i,
  input  logic [WIDTH-1:0]                 wr_en_i,
  input  logic [WIDTH*PHYS_REG_BITS-1:0]   rd_phys_i,
  output logic [WIDTH*PHYS_REG_BITS-1:0]   rs1_phys_o,
  output logic [WIDTH*PHYS_REG_BITS-1:0]   rs2_phys_o,
  output logic [WIDTH*PHYS_REG_BITS-1:0]   rd_phys_old_o,
  input  logic                             ckpt_req_i,
  input  logic [LANE_BITS-1:0]             ckpt_lane_i,
  output logic                             ckpt_avail_o,
  output logic [CKPT_BITS-1:0]             ckpt_tag_o,
  input  logic                             restore_en_i,
  input  logic [CKPT_BITS-1:0]             restore_tag_i,
  input  logic [NUM_CKPT-1:0]              restore_free_mask_i,
  input  logic                             free_en_i,
  input  logic [CKPT_BITS-1:0]             free_tag_i,
`ifdef RENAME_CKPT_STATS_EN
  output logic [CKPT_BITS:0]               ckpt_count_o,
  output logic [15:0]                      ckpt_drop_cnt_o,
`endif
  output logic                             restore_err_o
);

  logic [PHYS_REG_BITS-1:0] map_q  [NUM_ARCH_REGS];
  logic [PHYS_REG_BITS-1:0] map_d  [NUM_ARCH_REGS];
  logic [PHYS_REG_BITS-1:0] snap_d [NUM_ARCH_REGS];
  logic [PHYS_REG_BITS-1:0] ckpt_map_q [NUM_CKPT][NUM_ARCH_REGS];
  logic [NUM_CKPT-1:0]      ckpt_valid_q, ckpt_valid_d;
  logic                     restore_err_q, restore_err_d;
  logic                     ckpt_take;
  logic                     restore_hit;

  // Sources see the youngest earlier lane writing the same register, else the table.
  always_comb begin
    rs1_phys_o    = '0;
    rs2_phys_o    = '0;
    rd_phys_old_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      logic [4:0] s1, s2, d;
      logic [PHYS_REG_BITS-1:0] p1, p2, pd;
      s1 = rs1_arch_i[5*i +: 5];
      s2 = rs2_arch_i[5*i +: 5];
      d  = rd_arch_i[5*i +: 5];
      p1 = map_q[s1];
      p2 = map_q[s2];
      pd = map_q[d];
      for (int j = 0; j < WIDTH; j++) begin
        if (j < i && wr_en_i[j]) begin
          if (rd_arch_i[5*j +: 5] == s1) p1 = rd_phys_i[PHYS_REG_BITS*j +: PHYS_REG_BITS];
          if (rd_arch_i[5*j +: 5] == s2) p2 = rd_phys_i[PHYS_REG_BITS*j +: PHYS_REG_BITS];
          if (rd_arch_i[5*j +: 5] == d)  pd = rd_phys_i[PHYS_REG_BITS*j +: PHYS_REG_BITS];
        end
      end
      if (s1 == 5'd0) p1 = '0;
      if (s2 == 5'd0) p2 = '0;
      if (d  == 5'd0) pd = '0;
      rs1_phys_o[PHYS_REG_BITS*i +: PHYS_REG_BITS]    = p1;
      rs2_phys_o[PHYS_REG_BITS*i +: PHYS_REG_BITS]    = p2;
      rd_phys_old_o[PHYS_REG_BITS*i +: PHYS_REG_BITS] = pd;
    end
  end

  always_comb begin
    ckpt_tag_o = '0;
    for (int k = NUM_CKPT - 1; k >= 0; k--) begin
      if (!ckpt_valid_q[k]) ckpt_tag_o = CKPT_BITS'(k);
    end
  end

  assign ckpt_avail_o = |(~ckpt_valid_q);
  assign restore_hit  = ckpt_valid_q[restore_tag_i];
  assign ckpt_take    = ckpt_req_i && ckpt_avail_o && !restore_en_i;

  // Lanes apply in order; the snapshot is captured right after the branch lane.
  always_comb begin
    for (int r = 0; r < NUM_ARCH_REGS; r++) begin
      map_d[r]  = map_q[r];
      snap_d[r] = map_q[r];
    end
    for (int i = 0; i < WIDTH; i++) begin
      if (wr_en_i[i] && rd_arch_i[5*i +: 5] != 5'd0)
        map_d[rd_arch_i[5*i +: 5]] = rd_phys_i[PHYS_REG_BITS*i +: PHYS_REG_BITS];
      if (LANE_BITS'(i) == ckpt_lane_i) begin
        for (int r = 0; r < NUM_ARCH_REGS; r++) snap_d[r] = map_d[r];
      end
    end
    if (restore_en_i) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++)
        map_d[r] = restore_hit ? ckpt_map_q[restore_tag_i][r] : map_q[r];
    end
  end

  // Free is applied before the allocation so a new checkpoint is never lost to it.
  always_comb begin
    ckpt_valid_d = ckpt_valid_q;
    if (free_en_i) ckpt_valid_d[free_tag_i] = 1'b0;
    if (restore_en_i) begin
      ckpt_valid_d[restore_tag_i] = 1'b0;
      ckpt_valid_d = ckpt_valid_d & ~restore_free_mask_i;
    end else if (ckpt_take) begin
      ckpt_valid_d[ckpt_tag_o] = 1'b1;
    end
    restore_err_d = restore_en_i && !restore_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) map_q[r] <= PHYS_REG_BITS'(r);
      ckpt_valid_q  <= '0;
      restore_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) map_q[r] <= map_d[r];
      ckpt_valid_q  <= ckpt_valid_d;
      restore_err_q <= restore_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ckpt_take) begin
      for (int r = 0; r < NUM_ARCH_REGS; r++) ckpt_map_q[ckpt_tag_o][r] <= snap_d[r];
    end
  end

  assign restore_err_o = restore_err_q;

`ifdef RENAME_CKPT_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    ckpt_count_o = '0;
    for (int k = 0; k < NUM_CKPT; k++)
      ckpt_count_o = ckpt_count_o + (CKPT_BITS+1)'(ckpt_valid_q[k]);
    drop_cnt_d = drop_cnt_q;
    if (ckpt_req_i && !ckpt_avail_o && !restore_en_i && drop_cnt_q != 16'hFFFF)
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign ckpt_drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rename_map_table_mw.sv
// Directed bench for rename_map_table_mw (WIDTH=2, NUM_CKPT=4) with hand-computed expectations.
module tb_rename_map_table_mw;
  localparam int PB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic [9:0]    rs1_arch, rs2_arch, rd_arch;
  logic [1:0]    wr_en;
  logic [13:0]   rd_phys;
  logic [13:0]   rs1_phys, rs2_phys, rd_phys_old;
  logic          ckpt_req;
  logic [0:0]    ckpt_lane;
  logic          ckpt_avail;
  logic [1:0]    ckpt_tag;
  logic          restore_en;
  logic [1:0]    restore_tag;
  logic [3:0]    restore_free_mask;
  logic          free_en;
  logic [1:0]    free_tag;
  logic          restore_err;
`ifdef RENAME_CKPT_STATS_EN
  logic [2:0]    ckpt_count;
  logic [15:0]   ckpt_drop_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  rename_map_table_mw dut (
    .clk(clk), .rst(rst),
    .rs1_arch_i(rs1_arch), .rs2_arch_i(rs2_arch), .rd_arch_i(rd_arch),
    .wr_en_i(wr_en), .rd_phys_i(rd_phys),
    .rs1_phys_o(rs1_phys), .rs2_phys_o(rs2_phys), .rd_phys_old_o(rd_phys_old),
    .ckpt_req_i(ckpt_req), .ckpt_lane_i(ckpt_lane),
    .ckpt_avail_o(ckpt_avail), .ckpt_tag_o(ckpt_tag),
    .restore_en_i(restore_en), .restore_tag_i(restore_tag),
    .restore_free_mask_i(restore_free_mask),
    .free_en_i(free_en), .free_tag_i(free_tag),
`ifdef RENAME_CKPT_STATS_EN
    .ckpt_count_o(ckpt_count), .ckpt_drop_cnt_o(ckpt_drop_cnt),
`endif
    .restore_err_o(restore_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_arch = '0; rs2_arch = '0; rd_arch = '0; wr_en = '0; rd_phys = '0;
    ckpt_req = 1'b0; ckpt_lane = '0; restore_en = 1'b0; restore_tag = '0;
    restore_free_mask = '0; free_en = 1'b0; free_tag = '0;
  endtask

  task automatic lane(input int l, input logic [4:0] s1, input logic [4:0] s2,
                      input logic [4:0] d, input logic w, input logic [PB-1:0] p);
    rs1_arch[5*l +: 5] = s1;
    rs2_arch[5*l +: 5] = s2;
    rd_arch[5*l +: 5]  = d;
    wr_en[l]           = w;
    rd_phys[PB*l +: PB] = p;
  endtask

  // Reads the committed table through lane 0 with no same-cycle writers.
  task automatic peek(input string tag, input logic [4:0] s, input logic [PB-1:0] exp);
    idle();
    rs1_arch[4:0] = s;
    #1;
    check(tag, 32'(rs1_phys[PB-1:0]), 32'(exp));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    lane(0, 5'd5, 5'd0, 5'd0, 1'b0, '0);
    #1;
    check("reset_rs1", 32'(rs1_phys[6:0]), 5);
    check("reset_rs2", 32'(rs2_phys[6:0]), 0);
    check("reset_tag", 32'(ckpt_tag), 0);
    check("reset_avail", 32'(ckpt_avail), 1);
    check("reset_err", 32'(restore_err), 0);

    // intra-group bypass
    idle();
    lane(0, 5'd0, 5'd0, 5'd3, 1'b1, 7'd40);
    lane(1, 5'd3, 5'd5, 5'd3, 1'b1, 7'd41);
    #1;
    check("byp_l1_rs1", 32'(rs1_phys[13:7]), 40);
    check("byp_l1_rs2", 32'(rs2_phys[13:7]), 5);
    check("byp_l1_old", 32'(rd_phys_old[13:7]), 40);
    check("byp_l0_old", 32'(rd_phys_old[6:0]), 3);
    tick();
    peek("byp_map3", 5'd3, 7'd41);

    // checkpoint at lane 0 excludes lane 1
    idle();
    lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 7'd50);
    lane(1, 5'd0, 5'd0, 5'd8, 1'b1, 7'd51);
    ckpt_req = 1'b1; ckpt_lane = 1'b0;
    #1;
    check("ck_tag0", 32'(ckpt_tag), 0);
    tick();
    peek("ck_map7", 5'd7, 7'd50);
    peek("ck_map8", 5'd8, 7'd51);
    check("ck_tag_next", 32'(ckpt_tag), 1);
    idle();
    lane(0, 5'd0, 5'd0, 5'd7, 1'b1, 7'd60);
    tick();
    peek("ck_map7_new", 5'd7, 7'd60);
    idle();
    restore_en = 1'b1; restore_tag = 2'd0;
    tick();
    peek("rs_map7", 5'd7, 7'd50);
    peek("rs_map8", 5'd8, 7'd8);
    peek("rs_map3", 5'd3, 7'd41);
    check("rs_err", 32'(restore_err), 0);
    check("rs_tag", 32'(ckpt_tag), 0);

    // exhaustion: snapshot k holds map[10]=70+k
    for (int k = 0; k < 4; k++) begin
      idle();
      lane(0, 5'd0, 5'd0, 5'd10, 1'b1, 7'(70 + k));
      ckpt_req = 1'b1;
      #1;
      check($sformatf("ex_tag%0d", k), 32'(ckpt_tag), 32'(k));
      tick();
    end
    check("ex_avail0", 32'(ckpt_avail), 0);
    idle();
    lane(0, 5'd0, 5'd0, 5'd11, 1'b1, 7'd80);
    ckpt_req = 1'b1;
    tick();
    check("ex_drop_avail", 32'(ckpt_avail), 0);
    peek("ex_drop_wr", 5'd11, 7'd80);
`ifdef RENAME_CKPT_STATS_EN
    check("ex_drop_cnt", 32'(ckpt_drop_cnt), 1);
    check("ex_count", 32'(ckpt_count), 4);
`endif
    idle();
    free_en = 1'b1; free_tag = 2'd1;
    tick();
    check("fr_tag", 32'(ckpt_tag), 1);
    check("fr_avail", 32'(ckpt_avail), 1);
    idle();
    ckpt_req = 1'b1;
    tick();
    check("fr_refill", 32'(ckpt_avail), 0);

    // restore priority over writes and checkpoint; valid -> 0011
    idle();
    restore_en = 1'b1; restore_tag = 2'd2; restore_free_mask = 4'b1000;
    lane(0, 5'd0, 5'd0, 5'd12, 1'b1, 7'd90);
    lane(1, 5'd0, 5'd0, 5'd13, 1'b1, 7'd91);
    ckpt_req = 1'b1;
    tick();
    peek("pr_map10", 5'd10, 7'd72);
    peek("pr_map11", 5'd11, 7'd11);
    peek("pr_map12", 5'd12, 7'd12);
    peek("pr_map13", 5'd13, 7'd13);
    check("pr_tag", 32'(ckpt_tag), 2);
`ifdef RENAME_CKPT_STATS_EN
    check("pr_count", 32'(ckpt_count), 2);
`endif

    // invalid restore of empty slot 3
    idle();
    restore_en = 1'b1; restore_tag = 2'd3;
    lane(0, 5'd0, 5'd0, 5'd14, 1'b1, 7'd95);
    tick();
    check("iv_err", 32'(restore_err), 1);
    peek("iv_map10", 5'd10, 7'd72);
    peek("iv_map14", 5'd14, 7'd14);
    check("iv_tag", 32'(ckpt_tag), 2);
    tick();
    check("iv_err_clr", 32'(restore_err), 0);

    // free and checkpoint together: freed slot not reused this cycle
    idle();
    free_en = 1'b1; free_tag = 2'd0; ckpt_req = 1'b1;
    #1;
    check("fc_tag", 32'(ckpt_tag), 2);
    tick();
    check("fc_tag_next", 32'(ckpt_tag), 0);
    idle();
    restore_en = 1'b1; restore_tag = 2'd1;
    tick();
    check("fc_err", 32'(restore_err), 0);
    peek("fc_map10", 5'd10, 7'd73);
    peek("fc_map11", 5'd11, 7'd80);

    // x0 never renamed; highest lane wins a collision
    idle();
    lane(0, 5'd0, 5'd0, 5'd0, 1'b1, 7'd99);
    lane(1, 5'd0, 5'd0, 5'd20, 1'b1, 7'd100);
    #1;
    check("x0_old", 32'(rd_phys_old[6:0]), 0);
    check("x0_l1_rs1", 32'(rs1_phys[13:7]), 0);
    tick();
    idle();
    lane(0, 5'd0, 5'd0, 5'd20, 1'b1, 7'd101);
    lane(1, 5'd0, 5'd0, 5'd20, 1'b1, 7'd102);
    #1;
    check("col_l0_old", 32'(rd_phys_old[6:0]), 100);
    check("col_l1_old", 32'(rd_phys_old[13:7]), 101);
    tick();
    peek("col_map20", 5'd20, 7'd102);

    // reset mid-operation
    idle();
    ckpt_req = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    peek("rr_map20", 5'd20, 7'd20);
    check("rr_tag", 32'(ckpt_tag), 0);
    check("rr_avail", 32'(ckpt_avail), 1);
    idle();
    restore_en = 1'b1; restore_tag = 2'd2;
    tick();
    check("rr_err", 32'(restore_err), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_map_table_mw.md
Name: rename_map_table_mw

Overview:
- Multi-lane successor of the single-port rename map table. Translates architectural to physical registers for WIDTH instructions per cycle.
- Resolves intra-group dependencies between earlier and later lanes in the same group.
- Owns NUM_CKPT internal branch-checkpoint slots, so recovery is by tag instead of by exporting and importing the whole table.
- Sits between decode and dispatch in the rename stage; the free list supplies rd_phys and the branch unit drives the restore and free ports.

Parameters:
- NUM_ARCH_REGS, 32: architectural registers (x0 hardwired).
- PHYS_REG_BITS, 7: physical tag width.
- WIDTH, 2: rename lanes per cycle (1..4).
- NUM_CKPT, 4: checkpoint slots (power of 2, ≥2). CKPT_BITS = $clog2(NUM_CKPT).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- rs1_arch  in  WIDTH*5  per-lane source 1; lane i occupies bits [5i+4:5i].
- rs2_arch  in  WIDTH*5  per-lane source 2.
- rd_arch  in  WIDTH*5  per-lane destination.
- wr_en  in  WIDTH  per-lane rename write enable.
- rd_phys  in  WIDTH*PHYS_REG_BITS  new physical destination per lane.
- rs1_phys  out  WIDTH*PHYS_REG_BITS  translated source 1 (combinational).
- rs2_phys  out  WIDTH*PHYS_REG_BITS  translated source 2 (combinational).
- rd_phys_old  out  WIDTH*PHYS_REG_BITS  previous mapping of rd, for ROB free-on-commit.
- ckpt_req  in  1  take a checkpoint this cycle.
- ckpt_lane  in  $clog2(WIDTH) (min 1)  lane holding the branch.
- ckpt_avail  out  1  at least one free slot.
- ckpt_tag  out  CKPT_BITS  slot that a request this cycle will use.
- restore_en  in  1  mispredict recovery.
- restore_tag  in  CKPT_BITS  slot to restore from.
- restore_free_mask  in  NUM_CKPT  younger slots to discard on restore.
- free_en  in  1  branch resolved correct.
- free_tag  in  CKPT_BITS  slot to release.
- restore_err  out  1  registered; pulses 1 cycle after restore of an invalid slot.

Behaviour:
- **Storage**
  - map[NUM_ARCH_REGS] registers.
  - ckpt_map[NUM_CKPT][NUM_ARCH_REGS] registers.
  - ckpt_valid[NUM_CKPT].
- **Reset**
  - map[i]=i (identity).
  - ckpt_valid=0 and restore_err=0.
  - Resulting outputs: ckpt_avail=1, ckpt_tag=0, and all source outputs equal their arch index.
- **Lookup (0 latency)**
  - Lane i source s = 0 gives 0.
  - Otherwise, the youngest earlier lane j<i with wr_en[j] && rd_arch[j]==s gives rd_phys[j].
  - Otherwise map[s].
  - rd_phys_old[i] uses the same rule on rd_arch[i]; rd_arch[i]==0 gives 0.
  - Lookups are never affected by restore_en in the same cycle.
- **Update (1 cycle)**
  - Lanes apply in order 0..WIDTH-1; the highest lane wins a same-rd collision.
  - Writes to rd=0 are ignored.
  - Updates are visible through map on the next cycle.
- **Checkpoint**
  - ckpt_tag = lowest index with ckpt_valid=0. ckpt_avail = |~ckpt_valid.
  - On ckpt_req && ckpt_avail: ckpt_map[ckpt_tag] <= map with lanes 0..ckpt_lane applied (later lanes excluded), and ckpt_valid[ckpt_tag] <= 1.
  - ckpt_req && !ckpt_avail is dropped with no state change. Upstream must stall on !ckpt_avail.
- **Restore** (priority over everything except rst)
  - If ckpt_valid[restore_tag]: map <= ckpt_map[restore_tag]. Then ckpt_valid[restore_tag] and all slots set in restore_free_mask are cleared.
  - All wr_en and ckpt_req in that cycle are ignored.
  - If the slot is invalid: map is unchanged, restore_free_mask is still applied, and restore_err=1 for 1 cycle.
- **Free**
  - free_en clears ckpt_valid[free_tag].
  - Freeing an already-invalid slot is a no-op.
- **Simultaneous events**
  - free_en and restore_en in the same cycle: both clears apply.
  - free_en and ckpt_req in the same cycle: the freed slot is not reused until the next cycle, because ckpt_tag is computed from the registered ckpt_valid.
- **Reset mid-operation:** all in-flight checkpoints are discarded and map returns to identity.

Optional Feature:
- Macro: RENAME_CKPT_STATS_EN.
- **Defined:** adds outputs:
  - ckpt_count [CKPT_BITS:0]: popcount of ckpt_valid.
  - ckpt_drop_cnt [15:0]: saturating at 16'hFFFF; increments on each dropped ckpt_req; cleared by rst.
- **Undefined:** these ports and their logic are absent. Core behaviour is identical in both cases.

Test Plan:
- **Reset identity:** after rst, lane0 rs1_arch=5, rs2_arch=0 → rs1_phys=5, rs2_phys=0; ckpt_tag=0, ckpt_avail=1.
- **Intra-group bypass:**
  - Stimulus: lane0 wr rd=3 → p40; lane1 rs1=3 and rd=3 → p41, same cycle.
  - Same cycle: lane1 rs1_phys=40, lane1 rd_phys_old=40, lane0 rd_phys_old=3.
  - Next cycle: map[3]=41.
- **Checkpoint at lane:**
  - Stimulus: lane0 rd=7 → p50, lane1 rd=8 → p51, ckpt_req with ckpt_lane=0; then a further write rd=7 → p60.
  - Restore of tag 0 → map[7]=50, map[8]=8.
- **Slot exhaustion:**
  - 4 ckpt_req → tags 0,1,2,3; then ckpt_avail=0.
  - A 5th request is dropped (ckpt_drop_cnt=1 with RENAME_CKPT_STATS_EN).
  - free_tag=1 → next ckpt_tag=1.
- **Restore priority:**
  - Stimulus: restore_en tag=2 with restore_free_mask=4'b1000, together with wr_en=2'b11 and ckpt_req.
  - Response: map equals snapshot 2; writes and checkpoint ignored; ckpt_valid=4'b0011.
- **Invalid restore:** restore_tag=3 with slot 3 empty → map unchanged, restore_err=1 for exactly 1 cycle.
